// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the multiply/divide unit:
//     - op_e      : operation encodings seen on the op port
//     - state_e   : control FSM states
//     - MUL_CNT_W : width of the multiply latency counter (covers MUL_CYCLES 1..8)
//   is_arith_op() identifies ops that occupy the unit (mul/div), as opposed to
//   the single-edge MTHI/MTLO moves and the no-op encodings.
// ---------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_e;

   localparam int MUL_CNT_W = $clog2(8) + 1;

   function automatic logic is_arith_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_divider.sv
// ---------------------------------------------------------------------------
// muldiv_divider
//   Iterative unsigned restoring divider, one quotient bit per clock.
//   The first step is taken on the start edge directly from the dividend and
//   divisor inputs, so after WIDTH edges (start edge included) quotient and
//   remainder are final and step_done is high for the following cycle.
//   A divisor of zero yields quotient all-ones and remainder = dividend; the
//   caller overrides that case anyway.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   clear      : abandon the current division (synchronous)
//   start      : load operands and take the first step
//   dividend   : WIDTH-bit unsigned dividend
//   divisor    : WIDTH-bit unsigned divisor
//   quotient   : current quotient register
//   remainder  : current partial remainder register
//   step_done  : all WIDTH steps complete; results valid this cycle
// ---------------------------------------------------------------------------
module muldiv_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             step_done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] dsr_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             run_reg;

   // One shared step datapath: on start it works on the raw inputs,
   // otherwise on the iteration registers.
   logic [WIDTH-1:0] src_rem;
   logic [WIDTH-1:0] src_quo;
   logic [WIDTH-1:0] src_dsr;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;

   always_comb begin
      src_rem  = start ? '0 : rem_reg;
      src_quo  = start ? dividend : quo_reg;
      src_dsr  = start ? divisor : dsr_reg;
      shifted  = {src_rem, src_quo[WIDTH-1]};
      diff     = shifted - {1'b0, src_dsr};
      quo_next = src_quo << 1;
      if (shifted >= {1'b0, src_dsr}) begin
         // Partial remainder stays below the divisor, so WIDTH bits suffice.
         rem_next    = diff[WIDTH-1:0];
         quo_next[0] = 1'b1;
      end else begin
         rem_next    = shifted[WIDTH-1:0];
         quo_next[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rem_reg <= '0;
         quo_reg <= '0;
         dsr_reg <= '0;
         cnt_reg <= '0;
         run_reg <= 1'b0;
      end else if (start) begin
         rem_reg <= rem_next;
         quo_reg <= quo_next;
         dsr_reg <= divisor;
         cnt_reg <= CNT_W'(WIDTH - 1);
         run_reg <= 1'b1;
      end else if (run_reg) begin
         if (cnt_reg != '0) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg - 1'b1;
         end else begin
            run_reg <= 1'b0;
         end
      end
   end

   assign quotient  = quo_reg;
   assign remainder = rem_reg;
   assign step_done = run_reg && (cnt_reg == '0);

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
//   MULT/MULTU: product registered on the start edge, written to {hi,lo}
//     MUL_CYCLES edges after (start edge counted as the first).
//   DIV/DIVU: magnitudes fed to the restoring divider; WIDTH step edges then
//     one sign-fixup edge writes lo=quotient, hi=remainder.
//   MTHI/MTLO: hi/lo take a on the next edge, no busy, no done.
//   done is a registered pulse in the cycle after hi/lo take a result.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   start, op  : muldiv instruction in EX and its encoding (muldiv_pkg::op_e)
//   a, b       : rs / rt operands
//   flush      : kill the in-flight op; also cancels a same-cycle start
//   stall_req  : combinational hold request for PC/IF_ID/ID_EXE
//   busy       : registered, FSM not idle
//   done       : one-cycle result pulse
//   hi, lo     : HI/LO registers
// ---------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             stall_req,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // The MUL state is entered only when MUL_CYCLES >= 2; it stays
   // MUL_CYCLES-1 cycles, counting this value down to zero.
   localparam logic [MUL_CNT_W-1:0] MUL_LOAD =
      (MUL_CYCLES >= 2) ? MUL_CNT_W'(MUL_CYCLES - 2) : '0;

   state_e                 state_reg;
   logic [MUL_CNT_W-1:0]   cnt_reg;
   logic [2*WIDTH-1:0]     prod_reg;
   logic [WIDTH-1:0]       a_reg;
   logic                   q_neg_reg;
   logic                   r_neg_reg;
   logic                   div0_reg;
   logic [WIDTH-1:0]       hi_reg;
   logic [WIDTH-1:0]       lo_reg;
   logic                   done_reg;

   logic                   accept;
   logic                   is_mul;
   logic                   is_div;
   logic                   signed_op;
   logic                   a_neg;
   logic                   b_neg;
   logic [WIDTH-1:0]       a_abs;
   logic [WIDTH-1:0]       b_abs;
   logic [2*WIDTH-1:0]     a_ext;
   logic [2*WIDTH-1:0]     b_ext;
   logic [2*WIDTH-1:0]     product;

   logic                   div_start;
   logic [WIDTH-1:0]       div_quo;
   logic [WIDTH-1:0]       div_rem;
   logic                   div_done;
   logic [WIDTH-1:0]       q_fix;
   logic [WIDTH-1:0]       r_fix;

   // Operand decode and preparation
   always_comb begin
      accept    = (state_reg == S_IDLE) && start && !flush;
      is_mul    = (op == OP_MULT) || (op == OP_MULTU);
      is_div    = (op == OP_DIV)  || (op == OP_DIVU);
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      a_neg     = signed_op && a[WIDTH-1];
      b_neg     = signed_op && b[WIDTH-1];
      // -2^(W-1) keeps its bit pattern, which is its correct unsigned magnitude.
      a_abs     = a_neg ? -a : a;
      b_abs     = b_neg ? -b : b;
      // Low 2W bits of the sign/zero-extended product are the exact result.
      a_ext     = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      b_ext     = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      product   = a_ext * b_ext;
      div_start = accept && is_div;
      q_fix     = q_neg_reg ? -div_quo : div_quo;
      r_fix     = r_neg_reg ? -div_rem : div_rem;
   end

   muldiv_divider #(
      .WIDTH (WIDTH)
   ) u_divider (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .start     (div_start),
      .dividend  (a_abs),
      .divisor   (b_abs),
      .quotient  (div_quo),
      .remainder (div_rem),
      .step_done (div_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         prod_reg  <= '0;
         a_reg     <= '0;
         q_neg_reg <= 1'b0;
         r_neg_reg <= 1'b0;
         div0_reg  <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        if (MUL_CYCLES == 1) begin
                           {hi_reg, lo_reg} <= product;
                           done_reg         <= 1'b1;
                        end else begin
                           prod_reg  <= product;
                           cnt_reg   <= MUL_LOAD;
                           state_reg <= S_MUL;
                        end
                     end
                     OP_DIV, OP_DIVU: begin
                        a_reg     <= a;
                        q_neg_reg <= a_neg ^ b_neg;
                        r_neg_reg <= a_neg;
                        div0_reg  <= (b == '0);
                        state_reg <= S_DIV;
                     end
                     OP_MTHI: hi_reg <= a;
                     OP_MTLO: lo_reg <= a;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               if (flush) begin
                  state_reg <= S_IDLE;
               end else if (cnt_reg == '0) begin
                  {hi_reg, lo_reg} <= prod_reg;
                  done_reg         <= 1'b1;
                  state_reg        <= S_IDLE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            S_DIV: begin
               if (flush) begin
                  state_reg <= S_IDLE;
               end else if (div_done) begin
                  // Sign fixup edge; divide by zero returns the raw dividend.
                  if (div0_reg) begin
                     hi_reg <= a_reg;
                     lo_reg <= '1;
                  end else begin
                     hi_reg <= r_fix;
                     lo_reg <= q_fix;
                  end
                  done_reg  <= 1'b1;
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Stall covers the issue cycle and every in-flight cycle; it drops in the
   // done cycle so a dependent MFHI/MFLO sees the freshly written value.
   assign stall_req = (state_reg != S_IDLE) || (accept && is_arith_op(op));
   assign busy      = (state_reg != S_IDLE);
   assign done      = done_reg;
   assign hi        = hi_reg;
   assign lo        = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_CYCLES=4).
module tb_muldiv_unit;

   localparam int W   = 32;
   localparam int MC  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    op = 3'd7;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          flush = 1'b0;
   logic          stall_req;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int passed = 0;
   int total  = 0;

   muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .stall_req (stall_req),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: plain integer arithmetic, returns {hi, lo}.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] res;
      res = '0;
      case (o)
         3'd0: begin
            sx = $signed(x); sy = $signed(y);
            res = 64'(sx * sy);
         end
         3'd1: res = {32'd0, x} * {32'd0, y};
         3'd2, 3'd3: begin
            if (y == 0) res = {x, 32'hFFFF_FFFF};
            else begin
               if (o == 3'd2) begin sx = $signed(x); sy = $signed(y); end
               else begin sx = {32'd0, x}; sy = {32'd0, y}; end
               q = sx / sy;
               r = sx % sy;
               res = {r[31:0], q[31:0]};
            end
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   // Issue one mul/div op and check latency, stall length, done pulse and HI/LO.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp);
      int n, stalls, lat;
      bit seen;
      lat = (o < 3'd2) ? MC : W + 1;
      @(posedge clk); #1;
      start = 1'b1; op = o; a = x; b = y;
      n = 0; stalls = 0; seen = 0;
      while (!seen && n < 200) begin
         #1;
         if (stall_req) stalls++;
         @(posedge clk); #1;
         start = 1'b0; op = 3'd7;
         n++;
         if (done) seen = 1;
      end
      #1;
      $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h edges=%0d stall=%0d", name, o, x, y, hi, lo, n, stalls);
      check({name, " latency"}, 64'(n), 64'(lat));
      check({name, " stall_cycles"}, 64'(stalls), 64'(lat));
      check({name, " hilo"}, {hi, lo}, exp);
      check({name, " done_cycle busy/stall"}, {62'd0, busy, stall_req}, 64'd0);
      @(posedge clk); #1;
      check({name, " done_pulse_width"}, 64'(done), 64'd0);
   endtask

   initial begin
      vec_t vt[9];
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      int cnt_done, n;

      vt[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vt[1] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14};
      vt[2] = '{3'd2, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFF2};
      vt[3] = '{3'd2, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
      vt[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
      vt[5] = '{3'd1, 32'd2,         32'd3,          32'd0,         32'd6};
      vt[6] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
      vt[7] = '{3'd3, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
      vt[8] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; #1;
      check("reset outputs", {hi, lo}, 64'd0);
      check("reset flags", {61'd0, busy, done, stall_req}, 64'd0);

      // Table-driven vectors
      foreach (vt[i]) run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo});

      // MTHI then MTLO back to back
      @(posedge clk); #1;
      start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
      #1;
      check("mthi issue stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      op = 3'd5; a = 32'h1234_5678; #1;
      $display("mthi -> hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
      check("mthi hi", 64'(hi), 64'hDEAD_BEEF);
      check("mthi flags", {61'd0, busy, done, stall_req}, 64'd0);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd7; #1;
      $display("mtlo -> hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
      check("mtlo hilo", {hi, lo}, 64'hDEAD_BEEF_1234_5678);
      check("mtlo flags", {62'd0, busy, done}, 64'd0);

      // Flush mid-divide from a clean reset
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
      @(posedge clk); #1; start = 1'b0; op = 3'd7;
      repeat (8) @(posedge clk);
      #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      $display("flush -> busy=%b hi=%h lo=%h", busy, hi, lo);
      check("flush busy", 64'(busy), 64'd0);
      check("flush hilo", {hi, lo}, 64'd0);
      cnt_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) cnt_done++;
      end
      check("flush no done", 64'(cnt_done), 64'd0);
      run_op("after_flush", 3'd1, 32'd2, 32'd3, 64'd6);

      // flush and start together in IDLE: both move and mul ignored
      @(posedge clk); #1;
      start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'h0BAD_0BAD;
      #1;
      check("flush+start stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      op = 3'd0; a = 32'd9; b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; op = 3'd7; #1;
      $display("flush+start -> hi=%h lo=%h busy=%b", hi, lo, busy);
      check("flush+start hilo", {hi, lo}, 64'd6);
      check("flush+start busy", 64'(busy), 64'd0);

      // Reset mid-divide clears everything
      @(posedge clk); #1;
      start = 1'b1; op = 3'd4; a = 32'hAAAA_5555;
      @(posedge clk); #1;
      op = 3'd2; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1; start = 1'b0; op = 3'd7;
      repeat (5) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; #1;
      $display("rst mid-div -> hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
      check("rst mid-div hilo", {hi, lo}, 64'd0);
      check("rst mid-div flags", {61'd0, busy, done, stall_req}, 64'd0);

      // Second start while busy is ignored
      @(posedge clk); #1;
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      @(posedge clk); #1; start = 1'b0; op = 3'd7;
      @(posedge clk); @(posedge clk); #1;
      start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
      @(posedge clk); #1; start = 1'b0; op = 3'd7;
      n = 4;
      while (!done && n < 200) begin
         @(posedge clk); #1; n++;
      end
      $display("busy start -> hi=%h lo=%h edges=%0d", hi, lo, n);
      check("busy start latency", 64'(n), 64'(W + 1));
      check("busy start hilo", {hi, lo}, {32'd2, 32'd14});

      // Randomised ops against the arithmetic model
      for (int k = 0; k < 40; k++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 4))
            0: rb = $urandom_range(0, 20);
            1: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if (k % 10 == 5) ra = 32'h8000_0000;
         run_op($sformatf("rand%0d", k), ro, ra, rb, model(ro, ra, rb));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
